// File: rtl/range_route_if.sv
// range_route_if: valid/ready header bus into and out of the range classifier (modports master=producer/consumer side, slave=classifier)
interface range_route_if #(
  parameter int WIDTH = 8,
  parameter int NUM_PORTS = 4,
  localparam int PW = $clog2(NUM_PORTS)
);
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic in_ready;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic [PW-1:0] out_port;
  logic out_ready;
  modport master (
    output in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, out_port
  );
  modport slave (
    input in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_port
  );
endinterface

// File: rtl/range_route_classifier.sv
// range_route_classifier: bins header bytes into NUM_PORTS ports by programmable thresholds; ports: clk, rst_n, bus (in/out handshake), cfg_we/cfg_idx/cfg_data/cfg_err (threshold programming), cnt_clr/cnt_sel/cnt_data (per-port hit counters)
module range_route_classifier #(
  parameter int WIDTH = 8,
  parameter int NUM_PORTS = 4,
  parameter int CNT_W = 16,
  parameter bit STRICT = 1'b0,
  localparam int PW = $clog2(NUM_PORTS)
) (
  input logic clk,
  input logic rst_n,
  range_route_if.slave bus,
  input logic cfg_we,
  input logic [PW-1:0] cfg_idx,
  input logic [WIDTH-1:0] cfg_data,
  output logic cfg_err,
  input logic cnt_clr,
  input logic [PW-1:0] cnt_sel,
  output logic [CNT_W-1:0] cnt_data
);
  logic [WIDTH-1:0] th [1:NUM_PORTS-1];
  logic [CNT_W-1:0] cnt [NUM_PORTS];
  logic [PW-1:0] port_next;
  logic accept;
  logic err_next;
  function automatic logic [WIDTH-1:0] def_th(input int i);
    logic [WIDTH+4:0] t;
    t = (WIDTH+5)'(i) << WIDTH;
    return WIDTH'(t / (WIDTH+5)'(NUM_PORTS));
  endfunction
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  // port is the number of thresholds passed, so non-monotonic tables still give a defined result
  always_comb begin
    port_next = '0;
    for (int i = 1; i < NUM_PORTS; i++)
      port_next = port_next + PW'(STRICT ? bus.in_data > th[i] : bus.in_data >= th[i]);
  end
  always_comb begin
    err_next = 1'b0;
    for (int i = 1; i < NUM_PORTS - 1; i++)
      err_next = err_next | (th[i+1] <= th[i]);
  end
  always_comb begin
    cnt_data = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      cnt_data = (cnt_sel == PW'(i)) ? cnt[i] : cnt_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_port <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data <= bus.in_data;
      bus.out_port <= port_next;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_PORTS; i++) th[i] <= def_th(i);
      cfg_err <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_PORTS; i++)
        if (cfg_we && cfg_idx == PW'(i)) th[i] <= cfg_data;
      cfg_err <= err_next;
    end
  end
  // clear wins over a same-cycle hit; counters stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (cnt_clr) cnt[i] <= '0;
        else if (accept && port_next == PW'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
    end
  end
endmodule
